// File: rtl/ps2_dev_tx_multi.sv
// N-channel PS/2 device-side transmitter: per-channel byte FIFO and 11-bit frame serializer,
// all channels paced by one shared PS/2 clock divider.
// Optional feature macro: PS2_HOST_INHIBIT_EN (host clock-inhibit sensing with frame abort/retry).
module ps2_dev_tx_multi #(
  parameter int unsigned CHANNELS  = 2,
  parameter int unsigned FIFO_BITS = 3,
  parameter int unsigned PS2DIV    = 1000
) (
  input  logic                              clk_sys,
  input  logic                              reset_n,
  input  logic [CHANNELS-1:0]               wr_en,
  input  logic [8*CHANNELS-1:0]             wr_data,
  input  logic [CHANNELS-1:0]               ovf_clr,
  input  logic [CHANNELS-1:0]               ps2_clk_in,
  output logic [CHANNELS-1:0]               ps2_clk,
  output logic [CHANNELS-1:0]               ps2_data,
  output logic [(FIFO_BITS+1)*CHANNELS-1:0] fifo_level,
  output logic [CHANNELS-1:0]               fifo_full,
  output logic [CHANNELS-1:0]               overflow
);

  localparam int unsigned Depth = 2 ** FIFO_BITS;
  localparam int unsigned CntW  = (PS2DIV > 1) ? $clog2(PS2DIV) : 1;
  localparam logic [CntW-1:0]    CntMax    = CntW'(PS2DIV - 1);
  localparam logic [FIFO_BITS:0] LevelFull = (FIFO_BITS + 1)'(Depth);

  typedef enum logic [1:0] {StIdle, StShift, StParity, StStop} state_e;

  logic [CntW-1:0] cnt_q;
  logic            clk_ps2_q;
  logic            tick;

  // Tick marks the cycle whose closing edge raises clk_ps2; serializers update on that edge.
  assign tick = (cnt_q == CntMax) && !clk_ps2_q;

  // Shared PS/2 clock divider
  always_ff @(posedge clk_sys) begin
    if (!reset_n) begin
      cnt_q     <= '0;
      clk_ps2_q <= 1'b0;
    end else if (cnt_q == CntMax) begin
      cnt_q     <= '0;
      clk_ps2_q <= ~clk_ps2_q;
    end else begin
      cnt_q <= cnt_q + 1'b1;
    end
  end

`ifdef PS2_HOST_INHIBIT_EN
`else
  logic unused_ps2_clk_in;
  assign unused_ps2_clk_in = ^ps2_clk_in;
`endif

  for (genvar c = 0; c < CHANNELS; c++) begin : g_ch
    logic [7:0]           mem_q [Depth];
    logic [FIFO_BITS-1:0] wptr_q, rptr_q;
    logic [FIFO_BITS:0]   level_q;
    logic                 ovf_q;
    state_e               state_q, state_d;
    logic [7:0]           shreg_q;
    logic [2:0]           bit_q;
    logic                 parity_q, data_q, gate_q;
    logic                 full, push, pop, load;
    logic                 inhibit, abort;

`ifdef PS2_HOST_INHIBIT_EN
    logic [1:0] sync_q;

    // Two-flop synchronizer on the host clock sense line
    always_ff @(posedge clk_sys) begin
      if (!reset_n) sync_q <= 2'b11;
      else          sync_q <= {sync_q[0], ps2_clk_in[c]};
    end

    assign inhibit = !sync_q[1];
    // Host pulls the clock low while we are driving it high mid-frame
    assign abort   = inhibit && clk_ps2_q && (state_q != StIdle);
`else
    assign inhibit = 1'b0;
    assign abort   = 1'b0;
`endif

    // Serializer state register
    always_ff @(posedge clk_sys) begin
      if (!reset_n) state_q <= StIdle;
      else          state_q <= state_d;
    end

    // Serializer next-state: advances only on tick, abort returns to idle at once
    always_comb begin
      state_d = state_q;
      if (abort) begin
        state_d = StIdle;
      end else if (tick) begin
        unique case (state_q)
          StIdle:   if (load) state_d = StShift;
          StShift:  if (bit_q == 3'd7) state_d = StParity;
          StParity: state_d = StStop;
          StStop:   state_d = StIdle;
          default:  state_d = StIdle;
        endcase
      end
    end

    // FIFO and serializer control strobes
    always_comb begin
      full = (level_q == LevelFull);
      push = wr_en[c] && !full;
      load = tick && (state_q == StIdle) && (level_q != '0) && !inhibit;
`ifdef PS2_HOST_INHIBIT_EN
      // Byte stays queued until its stop bit completes so an aborted frame can be resent
      pop  = tick && (state_q == StStop) && !abort;
`else
      pop  = load;
`endif
    end

    // FIFO storage, no reset needed
    always_ff @(posedge clk_sys) begin
      if (push) mem_q[wptr_q] <= wr_data[8*c +: 8];
    end

    // FIFO pointers, level and sticky overflow
    always_ff @(posedge clk_sys) begin
      if (!reset_n) begin
        wptr_q  <= '0;
        rptr_q  <= '0;
        level_q <= '0;
        ovf_q   <= 1'b0;
      end else begin
        if (push) wptr_q <= wptr_q + 1'b1;
        if (pop)  rptr_q <= rptr_q + 1'b1;
        if (push && !pop)      level_q <= level_q + 1'b1;
        else if (pop && !push) level_q <= level_q - 1'b1;
        // Set beats clear when both land in the same cycle
        if (wr_en[c] && full) ovf_q <= 1'b1;
        else if (ovf_clr[c])  ovf_q <= 1'b0;
      end
    end

    // Frame datapath: shift register, bit count, running parity, line drivers
    always_ff @(posedge clk_sys) begin
      if (!reset_n) begin
        shreg_q  <= '0;
        bit_q    <= '0;
        parity_q <= 1'b0;
        data_q   <= 1'b1;
        gate_q   <= 1'b1;
      end else if (abort) begin
        data_q <= 1'b1;
        gate_q <= 1'b1;
      end else if (tick) begin
        // Clock gating lags STOP->IDLE by one tick so the stop bit still gets a falling edge
        gate_q <= (state_q == StIdle) && !load;
        unique case (state_q)
          StIdle: begin
            if (load) begin
              shreg_q  <= mem_q[rptr_q];
              parity_q <= 1'b1;
              data_q   <= 1'b0;
              bit_q    <= '0;
            end
          end
          StShift: begin
            data_q   <= shreg_q[0];
            shreg_q  <= {1'b0, shreg_q[7:1]};
            parity_q <= parity_q ^ shreg_q[0];
            bit_q    <= bit_q + 1'b1;
          end
          StParity: data_q <= parity_q;
          StStop:   data_q <= 1'b1;
          default:  data_q <= 1'b1;
        endcase
      end
    end

    assign ps2_clk[c]                                 = clk_ps2_q | gate_q;
    assign ps2_data[c]                                = data_q;
    assign fifo_level[c*(FIFO_BITS+1) +: FIFO_BITS+1] = level_q;
    assign fifo_full[c]                               = full;
    assign overflow[c]                                = ovf_q;
  end

endmodule
